// File: rtl/clk_period_meter.sv
// clk_period_meter: single-shot period / high-time measurement of a slow,
// asynchronous clock-like signal, counted in clkin cycles.
module clk_period_meter #(
  parameter int CNT_W       = 26,
  parameter int SYNC_STAGES = 2   // must be >= 2
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             sigin,
  input  logic             start,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             busy,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_pipe;
  logic                   s, s_d, rise;
  logic [CNT_W-1:0]       cnt, cnt_nxt, hcnt, hcnt_nxt;
  logic [CNT_W-1:0]       period_nxt, high_nxt;
  logic                   valid_nxt, ovf_nxt;

  assign s    = sync_pipe[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign busy = (state != IDLE);

  // Synchronizer chain plus one delay flop for rising-edge detection.
  always_ff @(posedge clkin) begin
    if (rst) begin
      sync_pipe <= '0;
      s_d       <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], sigin};
      s_d       <= s;
    end
  end

  // FSM state register.
  always_ff @(posedge clkin) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and datapath update. A start landing in the valid cycle is
  // dropped: the FSM is already back in IDLE there, so gate on valid too.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    hcnt_nxt   = hcnt;
    period_nxt = period;
    high_nxt   = high_time;
    valid_nxt  = 1'b0;
    ovf_nxt    = overflow;
    unique case (state)
      IDLE: begin
        if (start && !valid) begin
          cnt_nxt   = '0;
          hcnt_nxt  = '0;
          ovf_nxt   = 1'b0;
          state_nxt = ARM;
        end
      end
      ARM: begin
        if (rise) begin
          cnt_nxt   = CNT_ONE;
          hcnt_nxt  = CNT_ONE;
          state_nxt = MEASURE;
        end else if (cnt == CNT_MAX) begin
          // no edge ever arrived: report a saturated, empty result
          ovf_nxt    = 1'b1;
          period_nxt = CNT_MAX;
          high_nxt   = '0;
          valid_nxt  = 1'b1;
          state_nxt  = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      MEASURE: begin
        if (rise) begin
          period_nxt = cnt;
          high_nxt   = hcnt;
          valid_nxt  = 1'b1;
          state_nxt  = IDLE;
        end else if (cnt == CNT_MAX) begin
          // abort before cnt could wrap; hcnt <= cnt so it cannot wrap either
          ovf_nxt    = 1'b1;
          period_nxt = CNT_MAX;
          high_nxt   = hcnt;
          valid_nxt  = 1'b1;
          state_nxt  = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
          if (s) hcnt_nxt = hcnt + CNT_ONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counters and result registers; results hold until the next valid.
  always_ff @(posedge clkin) begin
    if (rst) begin
      cnt       <= '0;
      hcnt      <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      hcnt      <= hcnt_nxt;
      period    <= period_nxt;
      high_time <= high_nxt;
      valid     <= valid_nxt;
      overflow  <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: a 26-bit instance fed by a periodic
// pattern generator and a 6-bit instance driven by hand for saturation cases.
module tb_clk_period_meter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_sig, a_start, a_valid, a_busy, a_ovf;
  logic [25:0] a_period, a_high;
  logic        b_sig, b_start, b_valid, b_busy, b_ovf;
  logic [5:0]  b_period, b_high;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int a_vcnt    = 0;
  int hi_len    = 5;
  int lo_len    = 5;

  typedef struct {
    int hi;
    int lo;
    int exp_period;
    int exp_high;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  clk_period_meter #(.CNT_W(26), .SYNC_STAGES(2)) dut_a (
    .clkin(clk), .rst(rst), .sigin(a_sig), .start(a_start),
    .period(a_period), .high_time(a_high), .valid(a_valid),
    .busy(a_busy), .overflow(a_ovf)
  );

  clk_period_meter #(.CNT_W(6), .SYNC_STAGES(2)) dut_b (
    .clkin(clk), .rst(rst), .sigin(b_sig), .start(b_start),
    .period(b_period), .high_time(b_high), .valid(b_valid),
    .busy(b_busy), .overflow(b_ovf)
  );

  // periodic sigin for dut_a, changing away from the active edge
  initial begin
    int phase;
    phase = 0;
    a_sig = 1'b0;
    forever begin
      @(negedge clk);
      if (phase >= hi_len + lo_len - 1) phase = 0;
      else phase = phase + 1;
      a_sig = (phase < hi_len);
    end
  end

  // count valid pulses of dut_a
  always @(posedge clk) if (a_valid === 1'b1) a_vcnt <= a_vcnt + 1;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic wait_valid_a(input string name);
    bit got;
    got = 0;
    for (int c = 0; c < 2000 && !got; c++) begin
      if (a_valid === 1'b1) got = 1;
      else @(negedge clk);
    end
    chk({name, "_valid_seen"}, 64'(got), 64'd1);
  endtask

  task automatic wait_valid_b(input string name);
    bit got;
    got = 0;
    for (int c = 0; c < 300 && !got; c++) begin
      if (b_valid === 1'b1) got = 1;
      else @(negedge clk);
    end
    chk({name, "_valid_seen"}, 64'(got), 64'd1);
  endtask

  task automatic start_a(input string name);
    @(negedge clk); a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    chk({name, "_busy"}, 64'(a_busy), 64'd1);
  endtask

  task automatic start_b(input string name);
    @(negedge clk); b_start = 1'b1;
    @(negedge clk); b_start = 1'b0;
    chk({name, "_busy"}, 64'(b_busy), 64'd1);
  endtask

  initial begin
    int v0;
    bit seen;
    logic prev;
    vecs[0] = '{5, 5, 10, 5};
    vecs[1] = '{2, 6, 8, 2};
    vecs[2] = '{1, 3, 4, 1};
    vecs[3] = '{3, 1, 4, 3};
    vecs[4] = '{7, 2, 9, 7};
    vecs[5] = '{1, 1, 2, 1};

    rst = 1'b1; a_start = 1'b0; b_start = 1'b0; b_sig = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_a_period", 64'(a_period), 64'd0);
    chk("rst_a_high",   64'(a_high),   64'd0);
    chk("rst_a_valid",  64'(a_valid),  64'd0);
    chk("rst_a_busy",   64'(a_busy),   64'd0);
    chk("rst_a_ovf",    64'(a_ovf),    64'd0);
    chk("rst_b_busy",   64'(b_busy),   64'd0);
    chk("rst_b_ovf",    64'(b_ovf),    64'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // table of periodic patterns
    foreach (vecs[i]) begin
      hi_len = vecs[i].hi;
      lo_len = vecs[i].lo;
      repeat (30) @(negedge clk);
      start_a($sformatf("vec%0d", i));
      wait_valid_a($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_period", i), 64'(a_period), 64'(vecs[i].exp_period));
      chk($sformatf("vec%0d_high", i),   64'(a_high),   64'(vecs[i].exp_high));
      chk($sformatf("vec%0d_ovf", i),    64'(a_ovf),    64'd0);
    end

    // back-to-back starts, each in the cycle right after valid
    hi_len = 2; lo_len = 6;
    repeat (30) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      start_a($sformatf("b2b%0d", k));
      wait_valid_a($sformatf("b2b%0d", k));
      chk($sformatf("b2b%0d_period", k), 64'(a_period), 64'd8);
      chk($sformatf("b2b%0d_high", k),   64'(a_high),   64'd2);
    end

    // starts while busy and in the valid cycle are ignored
    hi_len = 5; lo_len = 5;
    repeat (30) @(negedge clk);
    v0 = a_vcnt;
    start_a("ign");
    repeat (6) @(negedge clk);
    a_start = 1'b1; @(negedge clk); a_start = 1'b0;
    wait_valid_a("ign");
    a_start = 1'b1; @(negedge clk); a_start = 1'b0;
    chk("ign_period", 64'(a_period), 64'd10);
    chk("ign_high",   64'(a_high),   64'd5);
    repeat (40) @(negedge clk);
    chk("ign_one_valid", 64'(a_vcnt - v0), 64'd1);
    chk("ign_idle",      64'(a_busy),      64'd0);

    // reset in the middle of MEASURE
    hi_len = 20; lo_len = 20;
    repeat (50) @(negedge clk);
    v0 = a_vcnt;
    start_a("rstm");
    seen = 0;
    prev = a_sig;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (a_sig && !prev) seen = 1;
      prev = a_sig;
    end
    chk("rstm_edge_seen", 64'(seen), 64'd1);
    repeat (10) @(negedge clk);
    chk("rstm_busy_before", 64'(a_busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstm_period", 64'(a_period), 64'd0);
    chk("rstm_high",   64'(a_high),   64'd0);
    chk("rstm_valid",  64'(a_valid),  64'd0);
    chk("rstm_busy",   64'(a_busy),   64'd0);
    chk("rstm_ovf",    64'(a_ovf),    64'd0);
    rst = 1'b0;
    hi_len = 4; lo_len = 3;
    repeat (30) @(negedge clk);
    chk("rstm_no_valid", 64'(a_vcnt - v0), 64'd0);
    start_a("post");
    wait_valid_a("post");
    chk("post_period", 64'(a_period), 64'd7);
    chk("post_high",   64'(a_high),   64'd4);

    // 6-bit instance: timeout in ARM with sigin held low
    b_sig = 1'b0;
    start_b("tmo");
    wait_valid_b("tmo");
    chk("tmo_period", 64'(b_period), 64'd63);
    chk("tmo_high",   64'(b_high),   64'd0);
    chk("tmo_ovf",    64'(b_ovf),    64'd1);

    // next start clears overflow; one edge then stuck high saturates
    start_b("stk");
    chk("stk_ovf_cleared", 64'(b_ovf), 64'd0);
    repeat (5) @(negedge clk);
    b_sig = 1'b1;
    wait_valid_b("stk");
    chk("stk_period", 64'(b_period), 64'd63);
    chk("stk_high",   64'(b_high),   64'd63);
    chk("stk_ovf",    64'(b_ovf),    64'd1);
    @(negedge clk);
    chk("stk_valid_pulse", 64'(b_valid), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
